// File: rtl/uart_tx_feeder_if.sv
// Write-side and TX-controller-side signals of the UART transmit feeder.
// master = system/TX environment, slave = the feeder itself.
interface uart_tx_feeder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  WR_EN;
    logic [DATA_WIDTH-1:0] WR_DATA;
    logic                  FULL;
    logic                  EMPTY;
    logic [ADDR_WIDTH:0]   COUNT;
    logic                  OVERFLOW;
    logic                  TX_BUSY;
    logic [DATA_WIDTH-1:0] TX_DATA;
    logic                  TX_DATA_VALID;
    logic                  TIMEOUT_ERR;

    modport master (
        output WR_EN, WR_DATA, TX_BUSY,
        input  FULL, EMPTY, COUNT, OVERFLOW, TX_DATA, TX_DATA_VALID, TIMEOUT_ERR
    );

    modport slave (
        input  WR_EN, WR_DATA, TX_BUSY,
        output FULL, EMPTY, COUNT, OVERFLOW, TX_DATA, TX_DATA_VALID, TIMEOUT_ERR
    );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte buffer draining into the UART TX controller: one VALID pulse per byte,
// then waits for BUSY to rise and fall (or time out) before the next byte.
module uart_tx_feeder #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 8,
    parameter int ADDR_WIDTH   = 3,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic             CLK,
    input  logic             RST,
    uart_tx_feeder_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'b001,
        WAIT_BUSY = 3'b010,
        WAIT_DONE = 3'b100
    } state_t;

    localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;
    localparam logic [3:0]            TMR_ONE  = 4'd1;
    localparam logic [3:0]            TMO_LAST = 4'(BUSY_TIMEOUT - 1);

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [3:0]            timer;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH:0]   count_nxt;

    // Both decisions use registered FULL/EMPTY, so a write into a full
    // buffer is dropped even when a pop frees a slot on the same edge.
    assign push = bus.WR_EN && !bus.FULL;
    assign pop  = (state == IDLE) && !bus.EMPTY && !bus.TX_BUSY;

    always_comb begin
        count_nxt = bus.COUNT;
        if (push && !pop)
            count_nxt = bus.COUNT + CNT_ONE;
        else if (pop && !push)
            count_nxt = bus.COUNT - CNT_ONE;
    end

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= bus.WR_DATA;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state             <= IDLE;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            timer             <= '0;
            bus.COUNT         <= '0;
            bus.FULL          <= 1'b0;
            bus.EMPTY         <= 1'b1;
            bus.OVERFLOW      <= 1'b0;
            bus.TX_DATA       <= '0;
            bus.TX_DATA_VALID <= 1'b0;
            bus.TIMEOUT_ERR   <= 1'b0;
        end else begin
            bus.OVERFLOW      <= bus.WR_EN && bus.FULL;
            bus.TX_DATA_VALID <= 1'b0;
            bus.TIMEOUT_ERR   <= 1'b0;
            bus.COUNT         <= count_nxt;
            bus.FULL          <= (count_nxt == FULL_CNT);
            bus.EMPTY         <= (count_nxt == '0);
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;

            case (state)
                IDLE: begin
                    if (pop) begin
                        bus.TX_DATA       <= mem[rd_ptr];
                        bus.TX_DATA_VALID <= 1'b1;
                        rd_ptr            <= rd_ptr + PTR_ONE;
                        timer             <= '0;
                        state             <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    timer <= timer + TMR_ONE;
                    if (bus.TX_BUSY) begin
                        state <= WAIT_DONE;
                    end else if (timer == TMO_LAST) begin
                        // Controller never started: the byte is abandoned.
                        bus.TIMEOUT_ERR <= 1'b1;
                        state           <= IDLE;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.TX_BUSY)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: queue-based reference model compared every cycle,
// plus directed scenarios with hand-derived latencies and byte orders.
module tb_uart_tx_feeder;
    localparam int DEPTH        = 8;
    localparam int BUSY_TIMEOUT = 4;

    logic CLK;
    logic RST;
    bit   tx_model_busy;
    bit   tx_force;
    bit   tx_ignore;
    bit   gap_chk;
    int   cyc;
    int   n_total;
    int   n_pass;

    uart_tx_feeder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

    uart_tx_feeder #(
        .DATA_WIDTH(8), .DEPTH(DEPTH), .ADDR_WIDTH(3), .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    assign bus.TX_BUSY = tx_model_busy | tx_force;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic bound_fail(input string nm);
        n_total++;
        $display("FAIL %s: got no event, expected one within the cycle budget (cycle %0d)", nm, cyc);
    endtask

    // TX controller stand-in: BUSY rises the cycle after VALID, stays 11 edges.
    always begin
        @(negedge CLK);
        if (bus.TX_DATA_VALID && !tx_ignore) begin
            @(posedge CLK);
            #1 tx_model_busy = 1'b1;
            repeat (11) @(posedge CLK);
            #1 tx_model_busy = 1'b0;
        end
    end

    // Reference model: a byte queue plus the lifetime of the byte in flight.
    logic [7:0] mq[$];
    bit   [7:0] m_data;
    bit         m_valid, m_tmo, m_ovf, m_inflight, m_busy_seen;
    int         m_age;

    always @(posedge CLK or negedge RST) begin
        int n;
        bit busy, launch;
        if (!RST) begin
            mq.delete();
            m_data = '0; m_valid = 0; m_tmo = 0; m_ovf = 0;
            m_inflight = 0; m_busy_seen = 0; m_age = 0;
        end else begin
            n      = mq.size();
            busy   = bus.TX_BUSY;
            launch = !m_inflight && n > 0 && !busy;
            m_tmo  = 0;
            if (m_inflight) begin
                m_age++;
                if (m_busy_seen) begin
                    if (!busy) m_inflight = 0;
                end else if (busy) begin
                    m_busy_seen = 1;
                end else if (m_age == BUSY_TIMEOUT) begin
                    m_tmo      = 1;
                    m_inflight = 0;
                end
            end
            m_valid = launch;
            if (launch) begin
                m_data      = mq.pop_front();
                m_inflight  = 1;
                m_busy_seen = 0;
                m_age       = 0;
            end
            m_ovf = bus.WR_EN && n == DEPTH;
            if (bus.WR_EN && n < DEPTH) mq.push_back(bus.WR_DATA);
        end
    end

    logic [7:0] vq_data[$];
    int         vq_cyc[$];
    int         tmo_q[$];
    int         last_fall;
    bit         prev_busy;

    always @(negedge CLK) begin
        chk("cmp_count", 32'(bus.COUNT), mq.size());
        chk("cmp_full", 32'(bus.FULL), 32'(mq.size() == DEPTH));
        chk("cmp_empty", 32'(bus.EMPTY), 32'(mq.size() == 0));
        chk("cmp_overflow", 32'(bus.OVERFLOW), 32'(m_ovf));
        chk("cmp_valid", 32'(bus.TX_DATA_VALID), 32'(m_valid));
        chk("cmp_timeout", 32'(bus.TIMEOUT_ERR), 32'(m_tmo));
        chk("cmp_tx_data", 32'(bus.TX_DATA), 32'(m_data));
        if (bus.TX_DATA_VALID) begin
            vq_data.push_back(bus.TX_DATA);
            vq_cyc.push_back(cyc);
            if (gap_chk) chk("valid_gap_after_busy_fall", cyc - last_fall, 2);
        end
        if (bus.TIMEOUT_ERR) tmo_q.push_back(cyc);
        if (prev_busy && !bus.TX_BUSY) last_fall = cyc;
        prev_busy = bus.TX_BUSY;
    end

    // Called just after a rising edge; returns just after the edge that takes the byte.
    task automatic write(input logic [7:0] d);
        bus.WR_EN   = 1'b1;
        bus.WR_DATA = d;
        @(posedge CLK);
        #1 bus.WR_EN = 1'b0;
    endtask

    task automatic wait_valid(input int budget, input string nm, output int vc);
        vc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (bus.TX_DATA_VALID) begin
                vc = cyc;
                return;
            end
        end
        bound_fail(nm);
    endtask

    task automatic wait_fall(input int budget, input string nm);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (bus.TX_BUSY) seen = 1;
            else if (seen) return;
        end
        bound_fail(nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wc, vc, rc;
        RST = 1'b0;
        bus.WR_EN = 1'b0;
        bus.WR_DATA = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_count", 32'(bus.COUNT), 0);
        chk("rst_empty", 32'(bus.EMPTY), 1);
        chk("rst_full", 32'(bus.FULL), 0);
        chk("rst_tx_data", 32'(bus.TX_DATA), 0);
        chk("rst_valid", 32'(bus.TX_DATA_VALID), 0);
        RST = 1'b1;
        @(posedge CLK); #1;

        // Single byte: the pop is the edge right after the write edge.
        write(8'hA5);
        wc = cyc;
        wait_valid(10, "a5_valid_wait", vc);
        chk("a5_latency", vc - wc, 1);
        chk("a5_data", 32'(bus.TX_DATA), 32'h A5);
        chk("a5_count", 32'(bus.COUNT), 0);
        @(negedge CLK);
        chk("a5_valid_width", 32'(bus.TX_DATA_VALID), 0);
        repeat (6) @(negedge CLK);
        chk("a5_busy_mid", 32'(bus.TX_BUSY), 1);
        chk("a5_hold", 32'(bus.TX_DATA), 32'h A5);
        repeat (20) @(posedge CLK); #1;

        // Burst into a stalled buffer (BUSY forced high), then drain in order.
        vq_data.delete();
        tx_force = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            write(8'(i));
            if (i == 8) begin
                chk("burst_full", 32'(bus.FULL), 1);
                chk("burst_count8", 32'(bus.COUNT), 8);
            end
            if (i == 9) begin
                chk("burst_overflow", 32'(bus.OVERFLOW), 1);
                chk("burst_count_after_ovf", 32'(bus.COUNT), 8);
            end
        end
        @(posedge CLK); #1;
        chk("burst_overflow_1cyc", 32'(bus.OVERFLOW), 0);
        repeat (4) @(posedge CLK); #1;
        chk("hold_no_valid", vq_data.size(), 0);
        tx_force = 1'b0;
        rc = cyc;
        wait_valid(10, "hold_release_wait", vc);
        chk("hold_release_latency", vc - rc, 1);
        chk("hold_first_byte", 32'(bus.TX_DATA), 32'h01);
        @(posedge CLK); #1;
        gap_chk = 1'b1;
        repeat (120) @(posedge CLK); #1;
        gap_chk = 1'b0;
        chk("burst_sent_n", vq_data.size(), 8);
        for (int i = 0; i < vq_data.size() && i < 8; i++)
            chk("burst_order", 32'(vq_data[i]), i + 1);

        // Push and pop on the same edge at COUNT=3, 20 bytes through 8 slots.
        vq_data.delete();
        tx_force = 1'b1;
        for (int i = 0; i < 3; i++) write(8'h40 + 8'(i));
        chk("se_preload", 32'(bus.COUNT), 3);
        tx_force = 1'b0;
        write(8'h43);
        chk("se_count", 32'(bus.COUNT), 3);
        chk("se_pop", 32'(bus.TX_DATA_VALID), 1);
        for (int i = 4; i < 20; i++) begin
            wait_fall(100, "se_fall_wait");
            @(posedge CLK); #1;
            write(8'h40 + 8'(i));
            chk("se_count", 32'(bus.COUNT), 3);
            chk("se_pop", 32'(bus.TX_DATA_VALID), 1);
        end
        repeat (80) @(posedge CLK); #1;
        chk("se_sent_n", vq_data.size(), 20);
        for (int i = 0; i < vq_data.size() && i < 20; i++)
            chk("se_order", 32'(vq_data[i]), 32'h40 + i);

        // Controller never answers: timeout 4 edges after VALID, next byte right after.
        vq_data.delete(); vq_cyc.delete(); tmo_q.delete();
        tx_ignore = 1'b1;
        write(8'hC1);
        wc = cyc;
        write(8'hC2);
        repeat (15) @(posedge CLK); #1;
        chk("tmo_valid_n", vq_cyc.size(), 2);
        chk("tmo_pulse_n", tmo_q.size(), 2);
        if (vq_cyc.size() == 2 && tmo_q.size() == 2) begin
            chk("tmo_first_valid", vq_cyc[0] - wc, 1);
            chk("tmo_delay", tmo_q[0] - vq_cyc[0], 4);
            chk("tmo_next_byte", vq_cyc[1] - tmo_q[0], 1);
            chk("tmo_first_data", 32'(vq_data[0]), 32'h C1);
            chk("tmo_second_data", 32'(vq_data[1]), 32'h C2);
        end
        tx_ignore = 1'b0;
        repeat (5) @(posedge CLK); #1;

        // Asynchronous reset mid-frame with five bytes queued.
        for (int i = 0; i < 6; i++) write(8'h D0 + 8'(i));
        chk("pre_rst_count", 32'(bus.COUNT), 5);
        chk("pre_rst_busy", 32'(bus.TX_BUSY), 1);
        #2 RST = 1'b0;
        #1;
        chk("arst_count", 32'(bus.COUNT), 0);
        chk("arst_empty", 32'(bus.EMPTY), 1);
        chk("arst_full", 32'(bus.FULL), 0);
        chk("arst_tx_data", 32'(bus.TX_DATA), 0);
        chk("arst_valid", 32'(bus.TX_DATA_VALID), 0);
        chk("arst_timeout", 32'(bus.TIMEOUT_ERR), 0);
        chk("arst_overflow", 32'(bus.OVERFLOW), 0);
        repeat (3) @(posedge CLK); #1;
        RST = 1'b1;
        vq_data.delete();
        repeat (30) @(posedge CLK); #1;
        chk("post_rst_no_valid", vq_data.size(), 0);
        chk("post_rst_count", 32'(bus.COUNT), 0);
        chk("post_rst_empty", 32'(bus.EMPTY), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
